ddr2_app_port_arbiter_0: RTL

DDR2_APP_PORT_ARBITER_0 -- requirements
Module: DDR2_app_port_arbiter_0

---
 rtl/ddr2_app_port_arbiter_0.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ddr2_app_port_arbiter_0.sv
// ddr2_app_port_arbiter_0
//
// Two-port arbiter in front of the DDR2 controller application FIFOs.
// A winning write request is first streamed beat by beat into the write-data
// FIFO, and its address is pushed only afterwards. This keeps every command
// behind its data in FIFO order. Read (and any non-write) requests are
// address-only.
//
// Handshake: a requester holds pN_req, pN_addr and its current beat stable.
// pN_wd_rd=1 means the presented beat is consumed at the next rising edge.
// pN_gnt=1 means the request is accepted at the next rising edge.
// req and addr may change in the cycle after gnt.
//
// Build option: DDR2_ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate, using a last-winner pointer
//   undefined -> port 0 always wins a simultaneous request
//
// Ports
//   clk0, rst_n               clock, synchronous active-low reset
//   init_done                 calibration complete; gates all grants
//   pN_req/addr/wdata/mask    requester N inputs (addr[34:32] = command)
//   pN_wd_rd, pN_gnt          beat-consumed / request-accepted (combinational)
//   app_af_addr/wren          address FIFO write port (registered)
//   app_wdf_data/mask/wren    write-data FIFO write port (registered)
//   af_almost_full            address FIFO backpressure
//   wdf_almost_full           write-data FIFO backpressure
//   dbg_state                 current FSM state (0 IDLE, 1 WDATA, 2 CMD)
module ddr2_app_port_arbiter_0 #(
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int BEATS  = 2
) (
  input  logic              clk0,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic [35:0]       p0_addr,
  input  logic [35:0]       p1_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [MASK_W-1:0] p0_mask,
  input  logic [MASK_W-1:0] p1_mask,
  output logic              p0_wd_rd,
  output logic              p1_wd_rd,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic [35:0]       app_af_addr,
  output logic              app_af_wren,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_mask_data,
  output logic              app_wdf_wren,
  input  logic              af_almost_full,
  input  logic              wdf_almost_full,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_CMD   = 2'd2
  } state_t;

  localparam int              CNT_W     = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [2:0]      CMD_WRITE = 3'b100;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  beat_cnt;
  logic              cur_port;   // owner of the transaction in flight
  logic              win_port;   // port that would win in IDLE this cycle
  logic [35:0]       win_addr;
  logic              win_is_wr;
  logic              grant_ok;
  logic              beat_take;
  logic              cmd_phase;
  logic [35:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_mask;

`ifdef DDR2_ARB_ROUND_ROBIN_EN
  logic last_win;

  // On a tie, the port that did not win last time goes first.
  always_comb begin
    if (p0_req && p1_req) win_port = ~last_win;
    else                  win_port = ~p0_req;
  end
`else
  // Fixed priority: port 0 whenever it asks.
  always_comb win_port = ~p0_req;
`endif

  always_comb begin
    win_addr  = win_port ? p1_addr : p0_addr;
    win_is_wr = (win_addr[34:32] == CMD_WRITE);
    // A write also needs room in the data FIFO before it is committed.
    grant_ok  = init_done && !af_almost_full && (p0_req || p1_req) &&
                (!win_is_wr || !wdf_almost_full);
    sel_addr  = cur_port ? p1_addr  : p0_addr;
    sel_wdata = cur_port ? p1_wdata : p0_wdata;
    sel_mask  = cur_port ? p1_mask  : p0_mask;
  end

  // Next state and combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    beat_take = 1'b0;
    cmd_phase = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_ok) state_nxt = win_is_wr ? S_WDATA : S_CMD;
      end
      S_WDATA: begin
        if (!wdf_almost_full) begin
          beat_take = 1'b1;
          if (beat_cnt == LAST_BEAT) state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        cmd_phase = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    p0_wd_rd = beat_take & ~cur_port;
    p1_wd_rd = beat_take &  cur_port;
    p0_gnt   = cmd_phase & ~cur_port;
    p1_gnt   = cmd_phase &  cur_port;
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      beat_cnt      <= '0;
      cur_port      <= 1'b0;
      app_af_addr   <= '0;
      app_af_wren   <= 1'b0;
      app_wdf_data  <= '0;
      app_mask_data <= '0;
      app_wdf_wren  <= 1'b0;
`ifdef DDR2_ARB_ROUND_ROBIN_EN
      last_win      <= 1'b1;
`endif
    end else begin
      app_wdf_wren <= beat_take;
      app_af_wren  <= cmd_phase;
      if (state == S_IDLE && grant_ok) cur_port <= win_port;
      if (beat_take) begin
        app_wdf_data  <= sel_wdata;
        app_mask_data <= sel_mask;
        beat_cnt      <= beat_cnt + CNT_W'(1);
      end
      // The address goes out even when af_almost_full is high: the
      // threshold leaves headroom for the one command already committed.
      if (cmd_phase) begin
        app_af_addr <= sel_addr;
        beat_cnt    <= '0;
`ifdef DDR2_ARB_ROUND_ROBIN_EN
        last_win    <= cur_port;
`endif
      end
    end
  end

  assign dbg_state = state;

endmodule
